// File: rtl/coin_accumulator_if.sv
// Coin-slot button inputs, synchronous clear and the registered cents total
// that feeds the display stage.
interface coin_accumulator_if #(
    parameter int WIDTH = 7
);
    logic             COIN_P;
    logic             COIN_N;
    logic             COIN_D;
    logic             COIN_Q;
    logic             CLEAR;
    logic [WIDTH-1:0] TOTAL;
    logic             COIN_ACK;
    logic             OVF;

    modport master (
        output COIN_P, COIN_N, COIN_D, COIN_Q, CLEAR,
        input  TOTAL, COIN_ACK, OVF
    );

    modport slave (
        input  COIN_P, COIN_N, COIN_D, COIN_Q, CLEAR,
        output TOTAL, COIN_ACK, OVF
    );
endinterface

// File: rtl/coin_accumulator.sv
// Synchronises and debounces four coin buttons, credits each press once and
// keeps a saturating cents total with a sticky overflow flag.
module coin_accumulator #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int P_VAL           = 1,
    parameter int N_VAL           = 5,
    parameter int D_VAL           = 10,
    parameter int Q_VAL           = 25
) (
    input logic               CLOCK_50,
    input logic               RESET_N,
    coin_accumulator_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = WIDTH + 2;
    localparam int EW = WIDTH + 3;

    localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0]    PV   = SW'(P_VAL);
    localparam logic [SW-1:0]    NV   = SW'(N_VAL);
    localparam logic [SW-1:0]    DV   = SW'(D_VAL);
    localparam logic [SW-1:0]    QV   = SW'(Q_VAL);
    localparam logic [EW-1:0]    MAXE = EW'((2 ** WIDTH) - 1);

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       req;
    logic [CW-1:0]    cnt [4];

    logic [SW-1:0]    sum;
    logic [EW-1:0]    ext;
    logic             clip;

    logic [WIDTH-1:0] total_q;
    logic             ack_q;
    logic             ovf_q;

    assign raw = {bus.COIN_Q, bus.COIN_D, bus.COIN_N, bus.COIN_P};

    // req is registered alongside the deb rise, so it is valid for the single
    // cycle after deb goes high and lines TOTAL up at edge DEBOUNCE_CYCLES+2.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            req   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            req   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                    req[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sum  = (req[0] ? PV : '0) + (req[1] ? NV : '0)
             + (req[2] ? DV : '0) + (req[3] ? QV : '0);
        ext  = EW'(total_q) + EW'(sum);
        clip = (ext > MAXE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            total_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.CLEAR) begin
            total_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q <= (sum != '0);
            if (clip) begin
                total_q <= '1;
                ovf_q   <= 1'b1;
            end else begin
                total_q <= ext[WIDTH-1:0];
            end
        end
    end

    assign bus.TOTAL    = total_q;
    assign bus.COIN_ACK = ack_q;
    assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with DEBOUNCE_CYCLES=4; inputs change
// and outputs are sampled on the falling clock edge.
module tb_coin_accumulator;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    coin_accumulator_if #(.WIDTH(7)) bus ();

    coin_accumulator #(
        .WIDTH          (7),
        .DEBOUNCE_CYCLES(4),
        .P_VAL          (1),
        .N_VAL          (5),
        .D_VAL          (10),
        .Q_VAL          (25)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] m);
        bus.COIN_P = m[0];
        bus.COIN_N = m[1];
        bus.COIN_D = m[2];
        bus.COIN_Q = m[3];
    endtask

    // Hold long enough to credit, then release and let the release debounce.
    task automatic press(input logic [3:0] m, output int acks);
        acks = 0;
        drive(m);
        repeat (8) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        drive(4'b0000);
        repeat (8) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
    endtask

    task automatic do_clear();
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
    endtask

    initial begin
        int acks;
        int exp_total;
        n_total = 0;
        n_bad   = 0;
        rst_n     = 1'b0;
        bus.CLEAR = 1'b0;
        drive(4'b0000);
        tick();
        tick();
        check("rst_total", int'(bus.TOTAL), 0);
        check("rst_ack", int'(bus.COIN_ACK), 0);
        check("rst_ovf", int'(bus.OVF), 0);
        rst_n = 1'b1;
        tick();

        // 1: quarter held 20 cycles credits once at edge 6
        acks = 0;
        drive(4'b1000);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.COIN_ACK) acks++;
            if (k == 5) check("t1_edge5_total", int'(bus.TOTAL), 0);
            if (k == 6) begin
                check("t1_edge6_total", int'(bus.TOTAL), 25);
                check("t1_edge6_ack", int'(bus.COIN_ACK), 1);
            end
            if (k == 7) check("t1_edge7_ack", int'(bus.COIN_ACK), 0);
        end
        drive(4'b0000);
        repeat (8) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        check("t1_acks", acks, 1);
        check("t1_total", int'(bus.TOTAL), 25);
        do_clear();
        check("clr_total", int'(bus.TOTAL), 0);

        // 2: 3-cycle glitch is ignored
        acks = 0;
        drive(4'b1000);
        repeat (3) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        drive(4'b0000);
        repeat (12) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        check("t2_acks", acks, 0);
        check("t2_total", int'(bus.TOTAL), 0);

        // 3: all four coins together
        press(4'b1111, acks);
        check("t3_acks", acks, 1);
        check("t3_total", int'(bus.TOTAL), 41);
        do_clear();

        // 4: five quarters, a dime that clips, then a penny at MAX
        exp_total = 0;
        for (int i = 0; i < 5; i++) begin
            press(4'b1000, acks);
            exp_total += 25;
            check("t4_q_acks", acks, 1);
            check("t4_q_total", int'(bus.TOTAL), exp_total);
        end
        check("t4_ovf_125", int'(bus.OVF), 0);
        press(4'b0100, acks);
        check("t4_d_acks", acks, 1);
        check("t4_d_total", int'(bus.TOTAL), 127);
        check("t4_d_ovf", int'(bus.OVF), 1);
        press(4'b0001, acks);
        check("t4_p_acks", acks, 1);
        check("t4_p_total", int'(bus.TOTAL), 127);
        check("t4_p_ovf", int'(bus.OVF), 1);

        // 5: CLEAR on the nickel's credit edge
        acks = 0;
        drive(4'b0010);
        repeat (6) tick();
        check("t5_pre_total", int'(bus.TOTAL), 127);
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        check("t5_total", int'(bus.TOTAL), 0);
        check("t5_ovf", int'(bus.OVF), 0);
        check("t5_ack", int'(bus.COIN_ACK), 0);
        repeat (4) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        drive(4'b0000);
        repeat (8) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        check("t5_acks", acks, 0);
        check("t5_total_after", int'(bus.TOTAL), 0);

        // 6: async reset mid-press with the dime held through release
        press(4'b1000, acks);
        check("t6_pre_total", int'(bus.TOTAL), 25);
        drive(4'b0100);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_total", int'(bus.TOTAL), 0);
        check("t6_async_ovf", int'(bus.OVF), 0);
        check("t6_async_ack", int'(bus.COIN_ACK), 0);
        tick();
        rst_n = 1'b1;
        acks = 0;
        repeat (20) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        drive(4'b0000);
        repeat (8) begin
            tick();
            if (bus.COIN_ACK) acks++;
        end
        check("t6_acks", acks, 1);
        check("t6_total", int'(bus.TOTAL), 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
